// File: rtl/cpu_trace_pkg.sv
// Shared types and entry layout for the LEGv8 run/trace monitor.
// Optional feature macro: TRACE_SNAPSHOT_EN (appends a full register snapshot to each trace entry).
package cpu_trace_pkg;

  // Run controller states; terminal states hold until reset.
  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RUN       = 2'd1,
    HALTED    = 2'd2,
    TIMED_OUT = 2'd3
  } run_state_e;

`ifdef TRACE_SNAPSHOT_EN
  localparam bit SNAPSHOT_EN = 1'b1;
`else
  localparam bit SNAPSHOT_EN = 1'b0;
`endif

  // Width of the snapshot field at the bottom of an entry (zero when disabled).
  function automatic int snap_w(input int num_regs, input int reg_w);
    return SNAPSHOT_EN ? num_regs * reg_w : 0;
  endfunction

  // Entry layout, MSB to LSB: {cycle, pc, mask[, regs_flat]}.
  function automatic int entry_w(input int num_regs, input int reg_w,
                                 input int addr_w, input int cyc_w);
    return cyc_w + addr_w + num_regs + snap_w(num_regs, reg_w);
  endfunction

  function automatic int mask_lsb(input int num_regs, input int reg_w);
    return snap_w(num_regs, reg_w);
  endfunction

  function automatic int pc_lsb(input int num_regs, input int reg_w);
    return mask_lsb(num_regs, reg_w) + num_regs;
  endfunction

  function automatic int cyc_lsb(input int num_regs, input int reg_w, input int addr_w);
    return pc_lsb(num_regs, reg_w) + addr_w;
  endfunction

endpackage

// File: rtl/cpu_trace_fifo.sv
// Synchronous first-word-fall-through FIFO for trace entries.
// A push into a full FIFO succeeds only when a pop happens on the same edge;
// otherwise the entry is dropped and the sticky ovf flag is raised.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cpu_trace_fifo
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Status, accepted transfers and the fall-through head word.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
               (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
  end

  // Pointer and overflow bookkeeping; reset empties the FIFO.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  // Storage array; contents are don't-care while not between the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/cpu_run_trace_monitor.sv
// Run controller and register-trace monitor for a LEGv8 core.
// Holds the core in reset after system reset, then watches PC and register
// taps, queueing one {cycle, pc, change-mask} record per cycle with any change.
// Stops on halt (PC unchanged for HALT_CYCLES cycles) or on watchdog timeout.
// Optional feature macro: TRACE_SNAPSHOT_EN (entries also carry regs_flat).
//
// Trace handshake: an entry transfers on every clock edge where trace_valid
// and trace_ready are both 1; while trace_valid is 1 and trace_ready is 0 the
// head entry on trace_data does not change.
module cpu_run_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int NUM_REGS       = 8,
  parameter int REG_W          = 16,
  parameter int ADDR_W         = 32,
  parameter int CYC_W          = 32,
  parameter int DEPTH          = 16,
  parameter int RESET_CYCLES   = 2,
  parameter int HALT_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 100,
  localparam int ENTRY_W       = entry_w(NUM_REGS, REG_W, ADDR_W, CYC_W)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         address,
  input  logic [NUM_REGS*REG_W-1:0] regs_flat,
  input  logic                      trace_ready,
  output logic                      cpu_reset,
  output logic                      running,
  output logic                      halted,
  output logic                      timed_out,
  output logic [CYC_W-1:0]          cycle_count,
  output logic                      trace_valid,
  output logic [ENTRY_W-1:0]        trace_data,
  output logic                      trace_ovf,
  output run_state_e                fsm_state
);

  localparam int RW       = NUM_REGS * REG_W;
  localparam int HOLD_W   = $clog2(RESET_CYCLES + 1);
  localparam int STAB_W   = $clog2(HALT_CYCLES + 1);
  localparam int MASK_LSB = mask_lsb(NUM_REGS, REG_W);
  localparam int PC_LSB   = pc_lsb(NUM_REGS, REG_W);
  localparam int CYC_LSB  = cyc_lsb(NUM_REGS, REG_W, ADDR_W);

  run_state_e          state;
  run_state_e          state_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                baseline_done;
  logic [RW-1:0]       prev_regs;
  logic [ADDR_W-1:0]   prev_pc;
  logic [STAB_W-1:0]   stable_cnt;

  logic [NUM_REGS-1:0] mask;
  logic                compare_en;
  logic                push;
  logic [ENTRY_W-1:0]  push_data;
  logic                pc_same;
  logic [STAB_W-1:0]   stable_nxt;
  logic [CYC_W-1:0]    count_nxt;
  logic                halt_hit;
  logic                timeout_hit;
  logic                fifo_empty;

  // Per-register change detection against last cycle's values.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      mask[i] = (regs_flat[i*REG_W +: REG_W] != prev_regs[i*REG_W +: REG_W]);
    end
  end

  // Compare, push and stop-condition decode for the current RUN cycle.
  // The first RUN cycle only captures the baseline, so nothing is compared.
  always_comb begin
    compare_en  = (state == RUN) && baseline_done;
    push        = compare_en && (mask != '0);
    pc_same     = (address == prev_pc);
    stable_nxt  = pc_same ? stable_cnt + STAB_W'(1) : '0;
    count_nxt   = cycle_count + CYC_W'(1);
    halt_hit    = compare_en && (stable_nxt == STAB_W'(HALT_CYCLES - 1));
    timeout_hit = (state == RUN) && (count_nxt == CYC_W'(TIMEOUT_CYCLES - 1));
  end

  // Trace entry assembly; snapshot bits exist only when the feature is built in.
  always_comb begin
    push_data = '0;
    push_data[CYC_LSB  +: CYC_W]    = cycle_count;
    push_data[PC_LSB   +: ADDR_W]   = address;
    push_data[MASK_LSB +: NUM_REGS] = mask;
`ifdef TRACE_SNAPSHOT_EN
    push_data[RW-1:0] = regs_flat;
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= HOLD;
    else        state <= state_nxt;
  end

  // Next-state logic; halt wins over a timeout detected on the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      HOLD: begin
        if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) state_nxt = RUN;
      end
      RUN: begin
        if (halt_hit)         state_nxt = HALTED;
        else if (timeout_hit) state_nxt = TIMED_OUT;
      end
      default: state_nxt = state;
    endcase
  end

  // State-decoded outputs; the flags are sticky because terminal states persist.
  always_comb begin
    cpu_reset = (state == HOLD);
    running   = (state == RUN);
    halted    = (state == HALTED);
    timed_out = (state == TIMED_OUT);
    fsm_state = state;
  end

  // Counters and baseline registers; they only move in HOLD and RUN.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_cnt      <= '0;
      baseline_done <= 1'b0;
      prev_regs     <= '0;
      prev_pc       <= '0;
      stable_cnt    <= '0;
      cycle_count   <= '0;
    end else begin
      case (state)
        HOLD: hold_cnt <= hold_cnt + HOLD_W'(1);
        RUN: begin
          prev_regs     <= regs_flat;
          prev_pc       <= address;
          baseline_done <= 1'b1;
          cycle_count   <= count_nxt;
          if (baseline_done) stable_cnt <= stable_nxt;
        end
        default: ;
      endcase
    end
  end

  cpu_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (trace_ready),
    .pop_data  (trace_data),
    .empty     (fifo_empty),
    .ovf       (trace_ovf)
  );

  // Valid whenever the FIFO holds an entry.
  always_comb trace_valid = !fifo_empty;

endmodule

// File: tb/tb_cpu_run_trace_monitor.sv
// Bench for cpu_run_trace_monitor: stimulus table, directed corner sequences
// and randomized episodes checked against a history-based reference model.
module tb_cpu_run_trace_monitor;
  import cpu_trace_pkg::*;

  localparam int NUM_REGS       = 8;
  localparam int REG_W          = 16;
  localparam int ADDR_W         = 32;
  localparam int CYC_W          = 32;
  localparam int DEPTH          = 4;
  localparam int RESET_CYCLES   = 2;
  localparam int HALT_CYCLES    = 8;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int ENTRY_W        = entry_w(NUM_REGS, REG_W, ADDR_W, CYC_W);
  localparam int RW             = NUM_REGS * REG_W;

  // ---------------- clock / reset / DUT ----------------
  logic                clock;
  logic                reset;
  logic [ADDR_W-1:0]   address;
  logic [RW-1:0]       regs_flat;
  logic                trace_ready;
  logic                cpu_reset;
  logic                running;
  logic                halted;
  logic                timed_out;
  logic [CYC_W-1:0]    cycle_count;
  logic                trace_valid;
  logic [ENTRY_W-1:0]  trace_data;
  logic                trace_ovf;
  run_state_e          fsm_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  cpu_run_trace_monitor #(
    .NUM_REGS(NUM_REGS), .REG_W(REG_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W),
    .DEPTH(DEPTH), .RESET_CYCLES(RESET_CYCLES), .HALT_CYCLES(HALT_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .regs_flat(regs_flat),
    .trace_ready(trace_ready), .cpu_reset(cpu_reset), .running(running),
    .halted(halted), .timed_out(timed_out), .cycle_count(cycle_count),
    .trace_valid(trace_valid), .trace_data(trace_data), .trace_ovf(trace_ovf),
    .fsm_state(fsm_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [CYC_W-1:0] c,
      input logic [ADDR_W-1:0] pc, input logic [NUM_REGS-1:0] m, input logic [RW-1:0] r);
`ifdef TRACE_SNAPSHOT_EN
    return {c, pc, m, r};
`else
    return {c, pc, m};
`endif
  endfunction

  function automatic logic [RW-1:0] set_reg(input logic [RW-1:0] r, input int i,
                                            input logic [REG_W-1:0] v);
    logic [RW-1:0] o;
    o = r;
    o[i*REG_W +: REG_W] = v;
    return o;
  endfunction

  // ---------------- reference model ----------------
  // Works from the run history: halt means the last HALT_CYCLES sampled PCs
  // are identical; the FIFO is a bounded queue of expected entries.
  int                 m_rel;
  bit                 m_run, m_halt, m_tout, m_ovf;
  logic [CYC_W-1:0]   m_cc;
  logic [ADDR_W-1:0]  pc_hist[$];
  logic [RW-1:0]      m_last_regs;
  logic [ENTRY_W-1:0] exp_q[$];

  task automatic model_edge(input bit rst, input logic [ADDR_W-1:0] a,
                            input logic [RW-1:0] r, input bit rdy);
    bit pop, have_push, halt;
    logic [NUM_REGS-1:0] m;
    logic [ENTRY_W-1:0] e;
    if (!rst) begin
      m_rel = 0; m_run = 0; m_halt = 0; m_tout = 0; m_ovf = 0; m_cc = '0;
      pc_hist.delete(); exp_q.delete();
      return;
    end
    pop = rdy && (exp_q.size() > 0);
    have_push = 0;
    e = '0;
    if (!m_run && !m_halt && !m_tout) begin
      m_rel++;
      if (m_rel == RESET_CYCLES) m_run = 1;
    end else if (m_run) begin
      if (pc_hist.size() > 0) begin
        for (int i = 0; i < NUM_REGS; i++)
          m[i] = (r[i*REG_W +: REG_W] != m_last_regs[i*REG_W +: REG_W]);
        if (m != '0) begin
          e = mk_entry(m_cc, a, m, r);
          have_push = 1;
        end
      end
      pc_hist.push_back(a);
      m_last_regs = r;
      halt = 0;
      if (pc_hist.size() >= HALT_CYCLES) begin
        halt = 1;
        for (int j = 1; j < HALT_CYCLES; j++)
          if (pc_hist[pc_hist.size() - 1 - j] != a) halt = 0;
      end
      m_cc = m_cc + 1;
      if (halt) begin
        m_run = 0; m_halt = 1;
      end else if (m_cc == CYC_W'(TIMEOUT_CYCLES - 1)) begin
        m_run = 0; m_tout = 1;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (have_push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(e);
      else m_ovf = 1;
    end
  endtask

  task automatic check_model();
    run_state_e st;
    logic [ENTRY_W-1:0] head;
    st = m_halt ? HALTED : m_tout ? TIMED_OUT : m_run ? RUN : HOLD;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("model_cpu_reset",   cpu_reset,   !(m_run || m_halt || m_tout));
    chk("model_running",     running,     m_run);
    chk("model_halted",      halted,      m_halt);
    chk("model_timed_out",   timed_out,   m_tout);
    chk("model_cycle_count", cycle_count, m_cc);
    chk("model_trace_valid", trace_valid, exp_q.size() > 0);
    chk("model_trace_data",  trace_data,  head);
    chk("model_trace_ovf",   trace_ovf,   m_ovf);
    chk("model_fsm_state",   fsm_state,   st);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input logic [ADDR_W-1:0] a,
                      input logic [RW-1:0] r, input bit rdy);
    reset = rst; address = a; regs_flat = r; trace_ready = rdy;
    @(posedge clock);
    model_edge(rst, a, r, rdy);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < RESET_CYCLES; i++) step(1'b1, '0, '0, 1'b0);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    bit                 rst;
    logic [ADDR_W-1:0]  addr;
    logic [RW-1:0]      regs;
    bit                 ready;
    bit                 e_cpu_reset;
    bit                 e_running;
    logic [CYC_W-1:0]   e_cc;
    bit                 e_valid;
    logic [ENTRY_W-1:0] e_data;
  } vec_t;

  function automatic vec_t mkv(input bit rst, input logic [ADDR_W-1:0] a,
      input logic [RW-1:0] r, input bit rdy, input bit ecr, input bit erun,
      input logic [CYC_W-1:0] ecc, input bit ev, input logic [ENTRY_W-1:0] ed);
    vec_t v;
    v.rst = rst; v.addr = a; v.regs = r; v.ready = rdy;
    v.e_cpu_reset = ecr; v.e_running = erun; v.e_cc = ecc; v.e_valid = ev; v.e_data = ed;
    return v;
  endfunction

  vec_t tbl [12];

  initial begin
    logic [RW-1:0] r_a5, r;
    logic [ADDR_W-1:0] a;
    reset = 1'b0; address = '0; regs_flat = '0; trace_ready = 1'b0;

    // Reset, hold, then reg3 0x0000->0x00A5 at cycle 5 with PC 0x40.
    r_a5 = set_reg('0, 3, 16'h00A5);
    tbl[0]  = mkv(0, 32'h0,  '0,   0, 1, 0, 0, 0, '0);
    tbl[1]  = mkv(0, 32'h0,  '0,   0, 1, 0, 0, 0, '0);
    tbl[2]  = mkv(0, 32'h0,  '0,   0, 1, 0, 0, 0, '0);
    tbl[3]  = mkv(1, 32'h0,  '0,   0, 1, 0, 0, 0, '0);
    tbl[4]  = mkv(1, 32'h0,  '0,   0, 0, 1, 0, 0, '0);
    tbl[5]  = mkv(1, 32'h2C, '0,   0, 0, 1, 1, 0, '0);
    tbl[6]  = mkv(1, 32'h30, '0,   0, 0, 1, 2, 0, '0);
    tbl[7]  = mkv(1, 32'h34, '0,   0, 0, 1, 3, 0, '0);
    tbl[8]  = mkv(1, 32'h38, '0,   0, 0, 1, 4, 0, '0);
    tbl[9]  = mkv(1, 32'h3C, '0,   0, 0, 1, 5, 0, '0);
    tbl[10] = mkv(1, 32'h40, r_a5, 0, 0, 1, 6, 1, mk_entry(5, 32'h40, 8'h08, r_a5));
    tbl[11] = mkv(1, 32'h44, r_a5, 1, 0, 1, 7, 0, '0);

    for (int k = 0; k < 12; k++) begin
      step(tbl[k].rst, tbl[k].addr, tbl[k].regs, tbl[k].ready);
      chk($sformatf("tbl%0d_cpu_reset", k), cpu_reset,   tbl[k].e_cpu_reset);
      chk($sformatf("tbl%0d_running", k),   running,     tbl[k].e_running);
      chk($sformatf("tbl%0d_cycle", k),     cycle_count, tbl[k].e_cc);
      chk($sformatf("tbl%0d_valid", k),     trace_valid, tbl[k].e_valid);
      chk($sformatf("tbl%0d_data", k),      trace_data,  tbl[k].e_data);
    end

    // Two registers change on the same cycle: one entry, mask 0x05.
    do_reset();
    step(1, 32'h100, '0, 0);
    step(1, 32'h104, '0, 0);
    r = set_reg(set_reg('0, 0, 16'h0001), 2, 16'h0007);
    step(1, 32'h108, r, 0);
    chk("multi_valid", trace_valid, 1'b1);
    chk("multi_entry", trace_data, mk_entry(2, 32'h108, 8'h05, r));

    // Overflow: four oldest entries kept, later ones dropped, drained in order.
    do_reset();
    step(1, 32'h200, '0, 0);
    for (int j = 1; j <= 6; j++) begin
      step(1, 32'h200 + 4 * j, set_reg('0, 1, REG_W'(j)), 0);
      if (j == 4) chk("ovf_at_full", trace_ovf, 1'b0);
    end
    chk("ovf_set", trace_ovf, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      chk($sformatf("drain%0d", j), trace_data,
          mk_entry(CYC_W'(j), 32'h200 + 4 * j, 8'h02, set_reg('0, 1, REG_W'(j))));
      step(1, 32'h200 + 4 * (6 + j), set_reg('0, 1, REG_W'(6)), 1);
    end
    chk("drain_empty", trace_valid, 1'b0);
    chk("ovf_sticky", trace_ovf, 1'b1);

    // Halt: PC held at 0x80 for 8 cycles.
    do_reset();
    for (int n = 0; n < 8; n++) begin
      step(1, 32'h80, '0, 1);
      if (n == 6) chk("halt_not_yet", halted, 1'b0);
    end
    chk("halt_flag", halted, 1'b1);
    chk("halt_running", running, 1'b0);
    chk("halt_cycle", cycle_count, 32'd8);
    for (int n = 0; n < 3; n++) step(1, 32'h84 + 4 * n, set_reg('0, 4, REG_W'(n + 1)), 1);
    chk("halt_no_push", trace_valid, 1'b0);
    chk("halt_frozen", cycle_count, 32'd8);

    // Timeout: PC never stable.
    do_reset();
    for (int n = 0; n < 99; n++) begin
      step(1, 32'h1000 + 4 * n, '0, 1);
      if (n == 97) chk("tout_not_yet", timed_out, 1'b0);
    end
    chk("tout_flag", timed_out, 1'b1);
    chk("tout_cycle", cycle_count, 32'd99);
    step(1, 32'h5000, '0, 1);
    step(1, 32'h5004, '0, 1);
    chk("tout_frozen", cycle_count, 32'd99);
    chk("tout_cpu_reset", cpu_reset, 1'b0);

    // Halt and timeout on the same cycle: halt wins.
    do_reset();
    for (int n = 0; n < 99; n++)
      step(1, (n < 91) ? 32'h1000 + 4 * n : 32'h2000, '0, 1);
    chk("both_halted", halted, 1'b1);
    chk("both_timed_out", timed_out, 1'b0);

    // Reset mid-run with a non-empty FIFO.
    do_reset();
    step(1, 32'h300, '0, 0);
    step(1, 32'h304, set_reg('0, 5, 16'h0001), 0);
    step(1, 32'h308, set_reg('0, 5, 16'h0001), 0);
    chk("abort_pre_valid", trace_valid, 1'b1);
    step(0, 32'h30C, set_reg('0, 5, 16'h0001), 0);
    chk("abort_valid", trace_valid, 1'b0);
    chk("abort_data", trace_data, '0);
    chk("abort_cpu_reset", cpu_reset, 1'b1);
    chk("abort_running", running, 1'b0);
    chk("abort_ovf", trace_ovf, 1'b0);
    chk("abort_state", fsm_state, HOLD);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 9; ep++) begin
      do_reset();
      a = $urandom;
      r = '0;
      for (int n = 0; n < 130; n++) begin
        bit rdy;
        if ((ep % 2) == 1) begin
          if ($urandom_range(0, 9) == 0) a = a + 4;
        end else begin
          if ($urandom_range(0, 19) != 0) a = a + 4;
        end
        if ($urandom_range(0, 2) == 0)
          r = set_reg(r, $urandom_range(0, NUM_REGS - 1), REG_W'($urandom_range(0, 3)));
        rdy = ((ep % 3) == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
        step(($urandom_range(0, 150) == 0) ? 1'b0 : 1'b1, a, r, rdy);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
